// File: rtl/sort4_seq_ctrl.sv
// rtl/sort4_seq_ctrl.sv - handshaked load/start/capture/replay sequencer for the 4-element sorter
module sort4_seq_ctrl #(
  parameter int DW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] srt_data,
  output logic          srt_load,
  output logic          srt_first,
  output logic          srt_start,
  input  logic          srt_done,
  input  logic [DW-1:0] srt_res,
  input  logic          srt_res_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          err,
  output logic [7:0]    grp_cnt
);

  localparam logic [2:0] S_FILL  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [7:0] T_LIM   = 8'(TIMEOUT);

  logic [2:0]    state;
  logic [1:0]    ecnt;
  logic [1:0]    wr;
  logic [1:0]    rd;
  logic [7:0]    tcnt;
  logic [7:0]    tnext;
  logic          accept;
  logic [DW-1:0] rbuf [4];

  assign in_ready  = (state == S_FILL);
  assign accept    = in_valid && in_ready;
  assign srt_start = (state == S_START);
  assign out_valid = (state == S_EMIT);
  assign out_last  = out_valid && (rd == 2'd3);
  assign out_data  = rbuf[rd];
  assign tnext     = tcnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FILL;
      ecnt      <= 2'd0;
      wr        <= 2'd0;
      rd        <= 2'd0;
      tcnt      <= 8'd0;
      srt_data  <= '0;
      srt_load  <= 1'b0;
      srt_first <= 1'b0;
      err       <= 1'b0;
      grp_cnt   <= 8'd0;
      for (int i = 0; i < 4; i++) rbuf[i] <= '0;
    end else begin
      srt_load  <= accept;
      srt_first <= accept && (ecnt == 2'd0);
      if (accept) srt_data <= in_data;

      case (state)
        S_FILL: begin
          if (accept) begin
            ecnt <= ecnt + 2'd1;
            if (ecnt == 2'd3) state <= S_START;
          end
        end
        S_START: begin
          tcnt  <= 8'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          tcnt <= tnext;
          // done wins over a timeout landing on the same cycle
          if (srt_done) begin
            state <= S_CAPT;
          end else if (tnext == T_LIM) begin
            err   <= 1'b1;
            state <= S_FILL;
          end
        end
        S_CAPT: begin
          if (srt_res_valid) begin
            rbuf[wr] <= srt_res;
            wr       <= wr + 2'd1;
            if (wr == 2'd3) state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            rd <= rd + 2'd1;
            if (rd == 2'd3) begin
              grp_cnt <= grp_cnt + 8'd1;
              state   <= S_FILL;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// tb/tb_sort4_seq_ctrl.sv - directed self-checking bench for sort4_seq_ctrl
module tb_sort4_seq_ctrl;

  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] srt_data;
  logic          srt_load;
  logic          srt_first;
  logic          srt_start;
  logic          srt_done;
  logic [DW-1:0] srt_res;
  logic          srt_res_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          err;
  logic [7:0]    grp_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  logic [2:0] wv [4];

  sort4_seq_ctrl #(.DW(DW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .srt_data(srt_data), .srt_load(srt_load), .srt_first(srt_first), .srt_start(srt_start),
    .srt_done(srt_done), .srt_res(srt_res), .srt_res_valid(srt_res_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .err(err), .grp_cnt(grp_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (srt_start) start_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [2:0] w [4], input int gap);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      in_data  = w[i];
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
        tick;
        n++;
      end
      check("feed_ready", int'(in_ready), 1);
      tick;
      in_valid = 1'b0;
      check("load", int'(srt_load), 1);
      check("load_data", int'(srt_data), int'(w[i]));
      check("first", int'(srt_first), (i == 0) ? 1 : 0);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          tick;
          check("idle_load", int'(srt_load), 0);
        end
      end
    end
    check("start", int'(srt_start), 1);
    check("ready_in_start", int'(in_ready), 0);
  endtask

  task automatic sorter(input int dly, input logic [2:0] r [4], input int rgap, input int nres);
    for (int i = 0; i < dly; i++) tick;
    srt_done = 1'b1;
    tick;
    srt_done = 1'b0;
    for (int i = 0; i < nres; i++) begin
      srt_res       = r[i];
      srt_res_valid = 1'b1;
      tick;
      srt_res_valid = 1'b0;
      for (int g = 0; g < rgap; g++) tick;
    end
  endtask

  task automatic drain(input logic [2:0] e [4], input logic [3:0] pat, input int grp_exp);
    int k;
    int n;
    k = 0;
    n = 0;
    while (k < 4 && n < 40) begin
      check("out_valid", int'(out_valid), 1);
      check("out_data", int'(out_data), int'(e[k]));
      check("out_last", int'(out_last), (k == 3) ? 1 : 0);
      out_ready = pat[n % 4];
      tick;
      if (out_ready) k++;
      n++;
    end
    out_ready = 1'b0;
    check("drain_count", k, 4);
    check("ready_after", int'(in_ready), 1);
    check("valid_after", int'(out_valid), 0);
    check("grp_cnt", int'(grp_cnt), grp_exp);
  endtask

  task automatic group(input logic [2:0] w [4], input int gap, input int dly, input int rgap,
                       input logic [3:0] pat, input int grp_exp);
    logic [2:0] r [4];
    logic [2:0] t;
    int s0;
    r = w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (r[j] > r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    s0 = start_cnt;
    feed(w, gap);
    sorter(dly, r, rgap, 4);
    drain(r, pat, grp_exp);
    check("start_pulses", start_cnt - s0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; srt_done = 1'b0;
    srt_res = '0; srt_res_valid = 1'b0; out_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    check("rst_out_data", int'(out_data), 0);
    check("rst_srt_data", int'(srt_data), 0);
    for (int i = 0; i < 10; i++) begin
      tick;
      check("idle_in_ready", int'(in_ready), 1);
      check("idle_load", int'(srt_load), 0);
      check("idle_start", int'(srt_start), 0);
      check("idle_out_valid", int'(out_valid), 0);
      check("idle_err", int'(err), 0);
      check("idle_grp", int'(grp_cnt), 0);
    end

    wv = '{3'd5, 3'd4, 3'd3, 3'd2};
    group(wv, 0, 3, 0, 4'b1111, 1);

    group(wv, 2, 2, 1, 4'b1001, 2);

    wv = '{3'd6, 3'd0, 3'd7, 3'd3};
    group(wv, 0, 15, 0, 4'b1111, 3);
    check("late_done_err", int'(err), 0);

    wv = '{3'd1, 3'd2, 3'd3, 3'd4};
    feed(wv, 0);
    for (int i = 0; i < 15; i++) tick;
    check("to_err_before", int'(err), 0);
    check("to_still_wait", int'(in_ready), 0);
    tick;
    check("to_err", int'(err), 1);
    check("to_fill", int'(in_ready), 1);
    check("to_grp", int'(grp_cnt), 3);
    check("to_out_valid", int'(out_valid), 0);

    wv = '{3'd3, 3'd1, 3'd2, 3'd0};
    group(wv, 1, 4, 0, 4'b1111, 4);
    check("err_sticky", int'(err), 1);

    wv = '{3'd5, 3'd4, 3'd3, 3'd2};
    feed(wv, 0);
    sorter(3, '{3'd2, 3'd3, 3'd4, 3'd5}, 0, 2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_grp", int'(grp_cnt), 0);
    check("rst_load", int'(srt_load), 0);

    wv = '{3'd7, 3'd1, 3'd6, 3'd0};
    group(wv, 0, 2, 0, 4'b1111, 1);
    check("post_rst_err", int'(err), 0);

    for (int g = 0; g < 255; g++) begin
      for (int i = 0; i < 4; i++) wv[i] = 3'($urandom_range(0, 7));
      group(wv, 0, 1, 0, 4'b1111, (g + 2) % 256);
    end
    check("wrap_grp", int'(grp_cnt), 0);
    check("wrap_err", int'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sort4_seq_ctrl.md
# sort4_seq_ctrl

Sequencing controller for the 4-element sequence sorter datapath (`sequence_input_compare`). It replaces the free-running test counter and fixed every-4th-cycle strobe with a handshaked front end. It collects exactly four input words, loads them into the sorter, starts it, and waits for completion with a timeout. It then captures the four sorted results and replays them downstream under valid/ready.

## Interface
Parameters:
- `DW`, 3, data word width.
- `TIMEOUT`, 15, maximum cycles spent in WAIT before abort (1..255).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in DW: input word.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: controller accepts a word this cycle.
- `srt_data` out DW: word presented to the sorter.
- `srt_load` out 1: `srt_data` is valid, one element per cycle.
- `srt_first` out 1: marks the first element of a group, qualified by `srt_load`.
- `srt_start` out 1: one-cycle start pulse after four loads.
- `srt_done` in 1: sorter finished, results follow.
- `srt_res` in DW: sorted result word.
- `srt_res_valid` in 1: result word valid.
- `out_data` out DW: sorted word to downstream.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: downstream accepts.
- `out_last` out 1: marks the 4th word of a group, qualified by `out_valid`.
- `err` out 1: sticky timeout flag, cleared only by `rst`.
- `grp_cnt` out 8: count of completed groups, wraps at 255 -> 0.

## Operation
- FSM states: FILL, START, WAIT, CAPT, EMIT. Reset state is FILL.
- FILL:
  - `in_ready`=1.
  - Each accepted word (`in_valid`&`in_ready`) is registered to `srt_data` with `srt_load`=1 on the next cycle.
  - `srt_first`=1 for element 0.
  - 2-bit element counter increments per accept.
  - On the 4th accept, go to START.
  - Idle cycles (`in_valid`=0) do not advance the counter.
- START: `srt_start`=1 for exactly one cycle, then WAIT. The timeout counter is cleared.
- WAIT:
  - The timeout counter increments each cycle.
  - If `srt_done`=1, go to CAPT.
  - If the counter reaches `TIMEOUT` without `srt_done`: set `err`=1, discard the group, go to FILL. `grp_cnt` is unchanged.
  - `srt_done` on the same cycle the counter reaches `TIMEOUT` counts as done, not timeout.
- CAPT:
  - Each `srt_res_valid` cycle writes `srt_res` into a 4-entry result buffer at the write index. Buffer order equals arrival order.
  - After the 4th write, go to EMIT.
  - `srt_res_valid` pulses may be non-contiguous; no timeout applies in CAPT.
- EMIT:
  - `out_valid`=1 and `out_data` = buffer[rd].
  - `rd` advances on `out_valid`&`out_ready`.
  - `out_last`=1 when `rd`=3.
  - On the accept with `rd`=3: increment `grp_cnt` and go to FILL.
  - `out_data` and `out_valid` hold stable while `out_ready`=0.
- `srt_res_valid` outside CAPT is ignored. `in_valid` outside FILL is not accepted.
- Reset values:
  - Control outputs: `in_ready`=1 (FILL), `srt_load`=0, `srt_first`=0, `srt_start`=0, `out_valid`=0, `out_last`=0.
  - Data and status: `srt_data`=0, `out_data`=0, `err`=0, `grp_cnt`=0.
  - Internal: all counters and indices = 0, result buffer = 0.
- `rst` asserted in any state returns to FILL on the next edge and drops any partial group.

## Timing
- Input accept to `srt_load` for that word: 1 cycle.
- 4th accept (cycle t):
  - `srt_load` for element 3 at t+1.
  - `srt_start` at t+1, same cycle as the last load.
  - WAIT from t+2.
- `srt_done` at cycle d: CAPT from d+1. Results may arrive with `srt_res_valid` from d+1.
- 4th result write at cycle c: `out_valid`=1 from c+1.
- With `out_ready` tied 1, the four outputs appear on consecutive cycles. FILL (`in_ready`=1) resumes the cycle after the `out_last` accept.
- Minimum group period: 4 (FILL) + 1 (START) + WAIT + 4 (CAPT) + 4 (EMIT) cycles.
- The timeout abort takes `TIMEOUT`+1 cycles after the START cycle, then FILL.

## Test plan
- Reset, then hold `in_valid`=0 for 10 cycles -> `in_ready`=1, `srt_load`=0, `srt_start`=0, `out_valid`=0, `err`=0, `grp_cnt`=0 throughout.
- Feed 5,4,3,2 back-to-back; model sorter raises `srt_done` 3 cycles after start, then results 2,3,4,5 on 4 cycles -> `srt_load` ×4 with `srt_first` on the first, `srt_start` once, then `out_data`=2,3,4,5 with `out_last` on 5, `grp_cnt`=1.
- Same group with `in_valid` gaps and `out_ready` toggling 1,0,0,1 -> no duplicated or lost words, `out_data` held during stalls, loads still ordered 5,4,3,2.
- Sorter never asserts `srt_done`, `TIMEOUT`=15 -> `err`=1 exactly 16 cycles after `srt_start`, FILL re-entered, `grp_cnt` unchanged. Next good group completes and `err` stays 1.
- Assert `rst` during CAPT after 2 results -> next cycle in FILL, `out_valid`=0, `err`=0, `grp_cnt`=0. A fresh group 7,1,6,0 then sorts correctly to 0,1,6,7.
- Run 256 groups -> `grp_cnt` wraps to 0, with no stall or state corruption.
